// File: rtl/fifo_word32.sv
// Word FIFO behind the 8->32 byte packer: in-order buffering with registered read data and sticky error flags.
// Optional `FIFO_OCCUPANCY_EN adds an occupancy output equal to the internal count register.
module fifo_word32 #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk_f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_OCCUPANCY_EN
    ,
    output logic [ADDR_WIDTH:0]   occupancy
`endif
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  pop_ok;
    logic                  push_ok;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = valid_in && (!full || pop_ok);

    assign full         = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= (ADDR_WIDTH+1)'(ALMOST_FULL_TH));
    assign almost_empty = (count <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH));

    // Storage is never cleared; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk_f) begin
        if (push_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

            if (pop_ok) begin
                data_out  <= mem[rd_ptr];
                valid_out <= 1'b1;
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
            end else begin
                valid_out <= 1'b0;
            end

            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase

            if (valid_in && !push_ok)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

`ifdef FIFO_OCCUPANCY_EN
    assign occupancy = count;
`else
    // Without the occupancy port the count register only feeds the status flags.
`endif

endmodule
